// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad entry path.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] COL_RESET   = 4'b1110;
  localparam int         NUM_DIGITS  = 6;
  localparam int         VALUE_WIDTH = 24;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus tick-paced stability counter for an active-low
// button; emits a one-clock strobe when the debounced level falls.
module input_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din_n,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    sync_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg   <= 2'b11;
      stable_reg <= 1'b1;
      cnt_reg    <= '0;
      fall       <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din_n};
      fall     <= 1'b0;
      if (tick) begin
        // Count consecutive ticks where the input disagrees with the accepted level.
        if (sync_reg[1] != stable_reg) begin
          if (cnt_reg == CW'(DEBOUNCE_TICKS - 1)) begin
            stable_reg <= sync_reg[1];
            cnt_reg    <= '0;
            fall       <= stable_reg & ~sync_reg[1];
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_input.sv
// 4x4 hex keypad scanner with debounce, 6-digit entry and CPU read handshake.
// Define KEYPAD_BACKSPACE_EN to make key 0xF act as backspace.
module keypad_input
  import keypad_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int unsigned DIVISOR        = 32'hFFFF,
  parameter int          DEBOUNCE_TICKS = 4
) (
  input  logic                   i_SYS_CLOCK,
  input  logic                   i_RESET,
  input  logic [3:0]             i_ROW_n,
  output logic [3:0]             o_COL_n,
  input  logic                   i_ENTER_n,
  input  logic                   i_READ_BUS,
  output logic [DATA_WIDTH-1:0]  o_BUS,
  output logic                   o_BUS_VALID,
  output logic                   o_READY,
  output logic [VALUE_WIDTH-1:0] o_VALUE,
  output logic [2:0]             o_DIGITS
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [31:0]            div_reg;
  logic                   tick;
  logic [3:0]             row_meta_reg;
  logic [3:0]             row_sync_reg;
  logic [3:0]             rows_low;
  state_t                 state_reg, state_next;
  logic [3:0]             col_reg, col_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [3:0]             code_reg, code_next;
  logic                   accept;
  logic                   enter_fall;
  logic [VALUE_WIDTH-1:0] value_reg;
  logic [2:0]             digits_reg;
  logic                   ready_reg;
  logic [DATA_WIDTH-1:0]  bus_reg;
  logic                   valid_reg;
  logic [DATA_WIDTH-1:0]  bus_data;

  assign tick     = (div_reg == DIVISOR - 1);
  assign rows_low = ~row_sync_reg;

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      div_reg      <= '0;
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      div_reg      <= tick ? 32'd0 : div_reg + 32'd1;
      row_meta_reg <= i_ROW_n;
      row_sync_reg <= row_meta_reg;
    end
  end

  input_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_enter (
    .clk  (i_SYS_CLOCK),
    .rst  (i_RESET),
    .tick (tick),
    .din_n(i_ENTER_n),
    .fall (enter_fall)
  );

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state_reg <= SCAN;
      col_reg   <= COL_RESET;
      cnt_reg   <= '0;
      code_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    accept     = 1'b0;
    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (is_onehot(rows_low)) begin
            code_next = {onehot_index(rows_low), onehot_index(~col_reg)};
            if (DEBOUNCE_TICKS == 1) begin
              accept     = 1'b1;
              state_next = HELD;
              cnt_next   = '0;
            end else begin
              state_next = DEBOUNCE;
              cnt_next   = CW'(1);
            end
          end else begin
            col_next = {col_reg[2:0], col_reg[3]};
          end
        end
        DEBOUNCE: begin
          // Only the exact latched row counts; an extra row is treated as a bounce.
          if (rows_low == (4'b0001 << code_reg[3:2])) begin
            if (cnt_reg == CW'(DEBOUNCE_TICKS - 1)) begin
              accept     = 1'b1;
              state_next = HELD;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end else begin
            state_next = SCAN;
            col_next   = {col_reg[2:0], col_reg[3]};
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (rows_low == 4'd0) begin
            if (cnt_reg == CW'(DEBOUNCE_TICKS - 1)) begin
              state_next = SCAN;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end else begin
            cnt_next = '0;
          end
        end
        default: begin
          state_next = SCAN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  generate
    if (DATA_WIDTH > VALUE_WIDTH) begin : g_zext
      assign bus_data = {{(DATA_WIDTH - VALUE_WIDTH){1'b0}}, value_reg};
    end else begin : g_trunc
      assign bus_data = value_reg[DATA_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      value_reg  <= '0;
      digits_reg <= 3'd0;
      ready_reg  <= 1'b0;
      bus_reg    <= '0;
      valid_reg  <= 1'b0;
    end else if (i_READ_BUS && ready_reg) begin
      bus_reg    <= bus_data;
      valid_reg  <= 1'b1;
      ready_reg  <= 1'b0;
      value_reg  <= '0;
      digits_reg <= 3'd0;
    end else begin
      if (!i_READ_BUS) valid_reg <= 1'b0;
      if (enter_fall && !ready_reg) ready_reg <= 1'b1;
      // Once an entry is complete it stays locked until the CPU reads it.
      if (accept && !ready_reg) begin
`ifdef KEYPAD_BACKSPACE_EN
        if (code_next == 4'hF) begin
          value_reg <= {4'h0, value_reg[VALUE_WIDTH-1:4]};
          if (digits_reg != 3'd0) digits_reg <= digits_reg - 3'd1;
        end else begin
          value_reg <= {value_reg[VALUE_WIDTH-5:0], code_next};
          if (digits_reg != 3'(NUM_DIGITS)) digits_reg <= digits_reg + 3'd1;
        end
`else
        value_reg <= {value_reg[VALUE_WIDTH-5:0], code_next};
        if (digits_reg != 3'(NUM_DIGITS)) digits_reg <= digits_reg + 3'd1;
`endif
      end
    end
  end

  assign o_COL_n     = col_reg;
  assign o_BUS       = bus_reg;
  assign o_BUS_VALID = valid_reg;
  assign o_READY     = ready_reg;
  assign o_VALUE     = value_reg;
  assign o_DIGITS    = digits_reg;

endmodule
